usr_ctrl: RTL and testbench
===========================

# usr_ctrl

Command sequencer for the 4-bit universal shift register. Accepts load/shift/rotate commands over a valid/ready interface. Drives the register's select, parallel-in and serial-in pins cycle by cycle for the requested number of shifts, then returns the resulting register contents over a valid/ready response channel. Sits between the block's command source and one universal shift register instance, and is the only driver of that register's control inputs.

## Interface
Parameters:
- CNT_W, 3, width of shift-count field (max 2^CNT_W-1 shifts per command)
- DONE_W, 8, width of completed-command counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  0=LOAD, 1=SHR (shift right), 2=SHL (shift left), 3=ROR (rotate right)
- cmd_data  in  4  parallel value for LOAD; ignored otherwise
- cmd_cnt  in  CNT_W  number of shift steps; ignored for LOAD
- cmd_fill  in  1  serial bit inserted each step for SHR/SHL
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  4  register contents after the command
- done_cnt  out  DONE_W  completed responses, wraps modulo 2^DONE_W
- usr_select  out  2  to register select: 0=right shift, 1=left shift, 2=parallel load, 3=hold
- usr_pdin  out  4  to register parallel input
- usr_l_in  out  1  to register left-shift serial input
- usr_r_in  out  1  to register right-shift serial input
- usr_pdout  in  4  from register parallel output

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1, usr_select=3. On cmd_valid&&cmd_ready, latch op, data, fill, and remaining count (rem=cmd_cnt). Go to EXEC if op=LOAD or cmd_cnt!=0. Otherwise, for a shift op with cmd_cnt=0, go directly to RESP.
- EXEC, LOAD: usr_select=2, usr_pdin=latched data, for exactly one cycle, then RESP.
- EXEC, SHR: usr_select=0, usr_r_in=latched fill.
- EXEC, SHL: usr_select=1, usr_l_in=latched fill.
- EXEC, ROR: usr_select=0, usr_r_in=usr_pdout[0] (combinational from the register's current value).
- For all shift ops, rem decrements every EXEC cycle. Leave EXEC to RESP on the cycle where rem==1.
- RESP: usr_select=3 (hold), rsp_valid=1, rsp_data=usr_pdout. On rsp_valid&&rsp_ready, increment done_cnt and return to IDLE.
- Outputs not in use in a state: usr_pdin, usr_l_in and usr_r_in are driven 0 whenever not selected by the current state/op.
- Control outputs: usr_select, usr_pdin, usr_l_in and usr_r_in are combinational from state and latched fields. They are never registered, so the register acts on the same edge the controller advances.
- cmd_ready=0 in EXEC and RESP. Only one command is in flight at a time.

## Timing
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, done_cnt=0, usr_select=3, usr_pdin=0, usr_l_in=0, usr_r_in=0, latched fields=0. rsp_data follows usr_pdout.
- Command accepted at edge k:
  - LOAD: EXEC in cycle k+1; rsp_valid from cycle k+2.
  - Shift op with count n>=1: EXEC in cycles k+1..k+n; rsp_valid from cycle k+n+1.
  - Shift op with n=0: rsp_valid from cycle k+1, register untouched.
- rsp_valid and rsp_data hold stable while rsp_ready=0 (register held with select=3).
- After response handshake at edge m, cmd_ready=1 in cycle m+1. There is no same-cycle command acceptance in RESP.
- Reset asserted in any state: next cycle IDLE, in-flight command dropped, no response, done_cnt=0.
- cmd_* inputs are don't-care unless cmd_valid=1 in IDLE. Changing them after acceptance has no effect.

## Test plan
- Reset, then LOAD data=4'hA -> rsp_valid 2 cycles after accept, rsp_data=4'hA, done_cnt=1.
- From 4'hA, SHR cnt=2 fill=1 -> usr_select=0 for exactly 2 cycles, rsp_data=4'hE.
- From 4'hE, SHL cnt=3 fill=0 -> rsp_data=4'h0. Then LOAD 4'h9, ROR cnt=1 -> 4'hC. Then ROR cnt=4 -> 4'hC (full rotation).
- SHR cnt=0 -> rsp_valid the cycle after accept, rsp_data unchanged, no EXEC cycle, usr_select stays 3.
- Response backpressure: hold rsp_ready=0 for 3 cycles after LOAD 4'h5 -> rsp_valid and rsp_data=4'h5 stable, cmd_ready=0 throughout. done_cnt increments only on the handshake edge.
- Reset asserted in the 2nd EXEC cycle of SHL cnt=5 -> IDLE next cycle, rsp_valid never asserts, done_cnt=0, register clears to 0. A following LOAD 4'h3 completes normally.

Source files
------------

// File: rtl/usr_ctrl.sv
// ---------------------------------------------------------------------------
// usr_ctrl
// Command sequencer for a 4-bit universal shift register.
//
// It accepts one load/shift/rotate command at a time over a valid/ready
// command channel. It then drives the register's select, parallel-in and
// serial-in pins, one step per cycle. When the command is finished, it
// returns the register contents over a valid/ready response channel.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op                      0=LOAD 1=SHR 2=SHL 3=ROR
//   cmd_data                    parallel value for LOAD
//   cmd_cnt                     number of shift steps (ignored for LOAD)
//   cmd_fill                    serial bit inserted by SHR/SHL
//   rsp_valid/rsp_ready         response handshake
//   rsp_data                    register contents after the command
//   done_cnt                    completed responses, wraps
//   usr_select                  register select: 0=right 1=left 2=load 3=hold
//   usr_pdin                    register parallel input
//   usr_l_in / usr_r_in         register serial inputs
//   usr_pdout                   register parallel output
// ---------------------------------------------------------------------------
module usr_ctrl #(
    parameter int CNT_W  = 3,
    parameter int DONE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_data,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic              cmd_fill,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_data,
    output logic [DONE_W-1:0] done_cnt,
    output logic [1:0]        usr_select,
    output logic [3:0]        usr_pdin,
    output logic              usr_l_in,
    output logic              usr_r_in,
    input  logic [3:0]        usr_pdout
);

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHR  = 2'd1;
    localparam logic [1:0] OP_SHL  = 2'd2;
    localparam logic [1:0] OP_ROR  = 2'd3;

    localparam logic [1:0] SEL_RIGHT = 2'd0;
    localparam logic [1:0] SEL_LEFT  = 2'd1;
    localparam logic [1:0] SEL_LOAD  = 2'd2;
    localparam logic [1:0] SEL_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [3:0]       data_q;
    logic             fill_q;
    logic [CNT_W-1:0] rem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_LOAD;
            data_q   <= 4'd0;
            fill_q   <= 1'b0;
            rem_q    <= '0;
            done_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        fill_q <= cmd_fill;
                        rem_q  <= cmd_cnt;
                        // A zero-count shift never touches the register.
                        if (cmd_op == OP_LOAD || cmd_cnt != '0)
                            state <= EXEC;
                        else
                            state <= RESP;
                    end
                end
                EXEC: begin
                    if (op_q == OP_LOAD) begin
                        state <= RESP;
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
                        // The last step happens on this edge, so leave now.
                        if (rem_q == CNT_W'(1))
                            state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        done_cnt <= done_cnt + DONE_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = usr_pdout;

    // Register controls are combinational, so the register takes each step
    // on the same edge that the controller uses to advance.
    always_comb begin
        usr_select = SEL_HOLD;
        usr_pdin   = 4'd0;
        usr_l_in   = 1'b0;
        usr_r_in   = 1'b0;
        if (state == EXEC) begin
            case (op_q)
                OP_LOAD: begin
                    usr_select = SEL_LOAD;
                    usr_pdin   = data_q;
                end
                OP_SHR: begin
                    usr_select = SEL_RIGHT;
                    usr_r_in   = fill_q;
                end
                OP_SHL: begin
                    usr_select = SEL_LEFT;
                    usr_l_in   = fill_q;
                end
                OP_ROR: begin
                    // Rotate: the bit leaving at the bottom re-enters at the top.
                    usr_select = SEL_RIGHT;
                    usr_r_in   = usr_pdout[0];
                end
                default: usr_select = SEL_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_ctrl.sv
module tb_usr_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       cmd_fill;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [7:0] done_cnt;
    logic [1:0] usr_select;
    logic [3:0] usr_pdin;
    logic       usr_l_in;
    logic       usr_r_in;
    logic [3:0] usr_pdout;

    int checks   = 0;
    int failures = 0;
    int exp_done = 0;
    logic [3:0] model_q = 4'd0;
    logic [3:0] last_rsp;

    usr_ctrl #(.CNT_W(3), .DONE_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .done_cnt(done_cnt),
        .usr_select(usr_select), .usr_pdin(usr_pdin),
        .usr_l_in(usr_l_in), .usr_r_in(usr_r_in), .usr_pdout(usr_pdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The universal shift register that the controller drives.
    logic [3:0] ureg;
    always_ff @(posedge clk) begin
        if (reset) ureg <= 4'd0;
        else begin
            case (usr_select)
                2'd0: ureg <= {usr_r_in, ureg[3:1]};
                2'd1: ureg <= {ureg[2:0], usr_l_in};
                2'd2: ureg <= usr_pdin;
                default: ureg <= ureg;
            endcase
        end
    end
    assign usr_pdout = ureg;

    // Reference result for a whole command, computed arithmetically.
    function automatic logic [3:0] ref_result(input logic [1:0] op, input logic [3:0] data,
                                              input logic [2:0] cnt, input logic fill,
                                              input logic [3:0] cur);
        int n, v, r;
        n = int'(cnt);
        v = int'(cur);
        case (op)
            2'd0: r = int'(data);
            2'd1: r = (n >= 4) ? (fill ? 15 : 0) : ((v >> n) | (fill ? ((15 << (4 - n)) & 15) : 0));
            2'd2: r = (n >= 4) ? (fill ? 15 : 0) : (((v << n) & 15) | (fill ? ((1 << n) - 1) : 0));
            default: begin
                n = n % 4;
                r = ((v >> n) | (v << (4 - n))) & 15;
            end
        endcase
        return 4'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                           input logic fill, input int delay);
        logic [3:0] exp_res;
        logic [3:0] held;
        int exp_exec;
        int execs;
        bit got;
        logic [1:0] exp_sel;
        exp_res  = ref_result(op, data, cnt, fill, model_q);
        exp_exec = (op == 2'd0) ? 1 : int'(cnt);
        exp_sel  = (op == 2'd0) ? 2'd2 : (op == 2'd2) ? 2'd1 : 2'd0;
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_sel", 32'(usr_select), 32'd3);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_fill = fill;
        tick();
        // Scramble the now-irrelevant command fields.
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_data = 4'($urandom);
        cmd_cnt = 3'($urandom); cmd_fill = 1'($urandom);
        execs = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            check("exec_sel", 32'(usr_select), 32'(exp_sel));
            check("exec_pdin", 32'(usr_pdin), (op == 2'd0) ? 32'(data) : 32'd0);
            check("exec_l_in", 32'(usr_l_in), (op == 2'd2) ? 32'(fill) : 32'd0);
            check("exec_r_in", 32'(usr_r_in),
                  (op == 2'd1) ? 32'(fill) : (op == 2'd3) ? 32'(usr_pdout[0]) : 32'd0);
            check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
            execs++;
            tick();
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
        check("exec_cycles", 32'(execs), 32'(exp_exec));
        check("rsp_data", 32'(rsp_data), 32'(exp_res));
        check("resp_sel", 32'(usr_select), 32'd3);
        check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        held = rsp_data;
        for (int i = 0; i < delay; i++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'(held));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_done", 32'(done_cnt), 32'(exp_done & 255));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_done++;
        check("hs_done", 32'(done_cnt), 32'(exp_done & 255));
        check("hs_valid", 32'(rsp_valid), 32'd0);
        check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        model_q  = exp_res;
        last_rsp = held;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0;
        cmd_cnt = 3'd0; cmd_fill = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_done", 32'(done_cnt), 32'd0);
        check("rst_sel", 32'(usr_select), 32'd3);
        check("rst_pdin", 32'(usr_pdin), 32'd0);
        check("rst_l_in", 32'(usr_l_in), 32'd0);
        check("rst_r_in", 32'(usr_r_in), 32'd0);

        run_cmd(2'd0, 4'hA, 3'd5, 1'b1, 0);
        check("plan_load_a", 32'(last_rsp), 32'hA);
        run_cmd(2'd1, 4'h0, 3'd2, 1'b1, 0);
        check("plan_shr2", 32'(last_rsp), 32'hE);
        run_cmd(2'd2, 4'h7, 3'd3, 1'b0, 1);
        check("plan_shl3", 32'(last_rsp), 32'h0);
        run_cmd(2'd0, 4'h9, 3'd0, 1'b0, 0);
        run_cmd(2'd3, 4'h0, 3'd1, 1'b0, 0);
        check("plan_ror1", 32'(last_rsp), 32'hC);
        run_cmd(2'd3, 4'h0, 3'd4, 1'b1, 0);
        check("plan_ror4", 32'(last_rsp), 32'hC);
        run_cmd(2'd1, 4'hF, 3'd0, 1'b1, 0);
        check("plan_shr0", 32'(last_rsp), 32'hC);
        run_cmd(2'd0, 4'h5, 3'd0, 1'b0, 3);
        check("plan_bp_load5", 32'(last_rsp), 32'h5);

        // Reset during the second EXEC cycle of SHL cnt=5.
        check("pre_rst_done", 32'(done_cnt), 32'(exp_done & 255));
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 4'h0; cmd_cnt = 3'd5; cmd_fill = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("mid_sel_exec1", 32'(usr_select), 32'd1);
        tick();
        check("mid_sel_exec2", 32'(usr_select), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_done = 0;
        model_q  = 4'd0;
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_done", 32'(done_cnt), 32'd0);
        check("mid_rst_sel", 32'(usr_select), 32'd3);
        check("mid_rst_reg", 32'(usr_pdout), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        run_cmd(2'd0, 4'h3, 3'd0, 1'b0, 0);
        check("post_rst_load3", 32'(last_rsp), 32'h3);

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
